// File: rtl/div_arbiter2.sv
// Two-requester round-robin front end for one shared 32-bit divider, with a WAIT timeout.
// Optional macro DIV_ZERO_CHECK_EN: zero divisors are answered locally without using the divider.
module div_arbiter2 #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] dvd0,
  input  logic [31:0] dvd1,
  input  logic [31:0] dvs0,
  input  logic [31:0] dvs1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] quo,
  output logic [31:0] rem,
  output logic        err,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_start,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  input  logic        div_fin
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t        state_q, state_d;
  logic          ptr_q, ptr_d;      // 0: requester 0 wins a tie
  logic          owner_q, owner_d;
  logic [31:0]   opa_q, opa_d;
  logic [31:0]   opb_q, opb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   quo_q, quo_d;
  logic [31:0]   rem_q, rem_d;
  logic          err_q, err_d;

  logic          grant_s;
  logic          gsel_s;
  logic [31:0]   sel_dvd_s;
  logic [31:0]   sel_dvs_s;
  logic          zdiv_s;

  // Arbitration: only in IDLE; a tie goes to the pointer, a lone request always wins.
  always_comb begin
    grant_s = 1'b0;
    gsel_s  = 1'b0;
    if ((state_q == IDLE) && !rst) begin
      if (req0 && req1) begin
        grant_s = 1'b1;
        gsel_s  = ptr_q;
      end else if (req0) begin
        grant_s = 1'b1;
        gsel_s  = 1'b0;
      end else if (req1) begin
        grant_s = 1'b1;
        gsel_s  = 1'b1;
      end else begin
        grant_s = 1'b0;
        gsel_s  = 1'b0;
      end
    end else begin
      grant_s = 1'b0;
      gsel_s  = 1'b0;
    end
  end

  assign sel_dvd_s = gsel_s ? dvd1 : dvd0;
  assign sel_dvs_s = gsel_s ? dvs1 : dvs0;

`ifdef DIV_ZERO_CHECK_EN
  assign zdiv_s = grant_s && (sel_dvs_s == 32'd0);
`else
  assign zdiv_s = 1'b0;
`endif

  // Next-state and datapath updates for the transaction FSM.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (grant_s) begin
          owner_d = gsel_s;
          ptr_d   = ~gsel_s;
          opa_d   = sel_dvd_s;
          opb_d   = sel_dvs_s;
          cnt_d   = '0;
          if (zdiv_s) begin
            quo_d   = 32'hFFFF_FFFF;
            rem_d   = sel_dvd_s;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // cnt_q counts completed WAIT cycles, so exiting at TIMEOUT-1 gives TIMEOUT cycles in WAIT.
        if (div_fin) begin
          quo_d   = div_q;
          rem_d   = div_r;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          quo_d   = 32'd0;
          rem_d   = 32'd0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = WAIT;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, pointer, operand and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      opa_q   <= 32'd0;
      opb_q   <= 32'd0;
      cnt_q   <= '0;
      quo_q   <= 32'd0;
      rem_q   <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  assign gnt0      = grant_s & ~gsel_s;
  assign gnt1      = grant_s & gsel_s;
  assign done0     = (state_q == RESP) & ~owner_q;
  assign done1     = (state_q == RESP) & owner_q;
  assign div_start = (state_q == LOAD) | (state_q == WAIT);
  assign div_a     = opa_q;
  assign div_b     = opb_q;
  assign quo       = quo_q;
  assign rem       = rem_q;
  assign err       = err_q;

endmodule

// File: doc/div_arbiter2.md
DIV_ARBITER2 -- requirements
Module: div_arbiter2

Interface
REQ-001 Parameter: TIMEOUT, default 64, max cycles spent in WAIT before forced error response.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req0, req1  input  1 each  division request from requester 0 / 1.
REQ-005 dvd0, dvd1  input  32 each  unsigned dividend for requester 0 / 1.
REQ-006 dvs0, dvs1  input  32 each  unsigned divisor for requester 0 / 1.
REQ-007 gnt0, gnt1  output  1 each  one-cycle grant pulse; operands captured this cycle.
REQ-008 done0, done1  output  1 each  one-cycle result-valid pulse to owner.
REQ-009 quo, rem  output  32 each  shared result bus; valid only while a doneN is high.
REQ-010 err  output  1  error flag, valid with doneN.
REQ-011 div_a, div_b  output  32 each  operands driven to the shared 32-bit divider.
REQ-012 div_start  output  1  divider enable.
REQ-013 div_q, div_r  input  32 each  divider quotient / remainder.
REQ-014 div_fin  input  1  divider completion flag.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, WAIT, RESP.
REQ-016 IDLE: with any reqN high, the block SHALL grant one requester, pulse gntN, latch its operands, record owner, go to LOAD.
REQ-017 Both requests high: grant SHALL go to the requester not served last (round-robin); a lone request SHALL be granted regardless of pointer.
REQ-018 Pointer SHALL update only on grant.
REQ-019 Requester holds reqN until gntN; reqN dropped before grant SHALL be a withdrawal with no effect.
REQ-020 reqN sampled outside IDLE SHALL be ignored until the next IDLE.
REQ-021 LOAD: div_a/div_b SHALL carry latched operands, div_start=1; next state WAIT.
REQ-022 div_a/div_b/div_start SHALL stay stable through WAIT; div_start=0 in IDLE and RESP.
REQ-023 WAIT: div_fin=1 SHALL latch div_q/div_r and go to RESP; div_fin outside WAIT SHALL be ignored.
REQ-024 WAIT cycle counter reaching TIMEOUT without div_fin SHALL go to RESP with quo=0, rem=0, err=1.
REQ-025 RESP: doneN of owner SHALL pulse exactly one cycle with quo/rem/err valid; next state IDLE.
REQ-026 Latency: gnt at cycle G, LOAD at G+1, WAIT from G+2, doneN the cycle after div_fin is sampled in WAIT.
REQ-027 At most one of gnt0/gnt1 and at most one of done0/done1 SHALL be high per cycle.
REQ-028 quo/rem/err SHALL hold last values outside RESP.

Reset
REQ-029 rst SHALL immediately force IDLE, pointer favouring requester 0, counter 0, all outputs 0.
REQ-030 Reset mid-operation SHALL abort the transaction with no doneN ever issued for it.

Configuration
REQ-031 Macro DIV_ZERO_CHECK_EN defined: a grant with divisor 0 SHALL bypass LOAD/WAIT, go directly to RESP, and return quo=32'hFFFFFFFF, rem=dividend, err=1 (done at G+1); div_start stays 0.
REQ-032 Macro undefined: divisor 0 SHALL be dispatched to the divider normally; only REQ-024 timeout guards it.

Verification
REQ-033 req0 with 1265/10, divider model fin after 33 cycles -> gnt0 pulse, done0 one cycle, quo=126, rem=5, err=0.
REQ-034 req0 and req1 high same cycle, after reset -> gnt0 first; req1 held -> gnt1 on next IDLE; repeat with both -> gnt0 again.
REQ-035 div_fin never asserted, TIMEOUT=64 -> doneN at G+2+64, quo=0, rem=0, err=1.
REQ-036 dvs0=0, dvd0=77: with DIV_ZERO_CHECK_EN -> done0 at G+1, quo=FFFFFFFF, rem=77, err=1; without -> div_start asserted, normal or timeout path.
REQ-037 rst pulsed during WAIT -> all outputs 0 immediately, no done pulse; next req served normally.
REQ-038 div_fin pulsed while IDLE, req1 dropped before grant -> no state change, no gnt, no done.
